gnn_save_scheduler: RTL and testbench

- Sequences save instructions into the save unit (AXI write-back of on-chip buffer groups 1_A/2_A/1_B/2_B).
- Queues incoming 128-bit save instructions and enforces per-buffer dependency tokens from the compute engine.
- Drives the save unit's ap_start/instruction pair, waits for ap_done, then optionally pulses a buffer-release back to compute.
- Sits between the instruction dispatcher and the save unit; one save is outstanding at a time.

---
 rtl/gnn_save_sched_pkg.sv | 45 ++++
 rtl/gnn_inst_fifo.sv | 61 ++++++
 rtl/gnn_save_scheduler.sv | 166 ++++++++++++++++
 tb/tb_gnn_save_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnn_save_sched_pkg.sv
// Shared constants for the save scheduler: instruction field positions, buffer indices, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gnn_save_sched_pkg;

    // Instruction field positions
    localparam int GRP_LSB  = 0;
    localparam int GRP_MSB  = 5;
    localparam int WAIT_BIT = 6;
    localparam int REL_BIT  = 7;

    // Buffer group indices (token counter / release bit position)
    localparam int BUF_1A  = 0;
    localparam int BUF_2A  = 1;
    localparam int BUF_1B  = 2;
    localparam int BUF_2B  = 3;
    localparam int NUM_BUF = 4;

    // FSM encoding kept as plain constants so it stays readable in legacy tools
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_CHECK   = 3'd1;
    localparam state_t S_START   = 3'd2;
    localparam state_t S_BUSY    = 3'd3;
    localparam state_t S_RELEASE = 3'd4;

    // A group field is usable only if the two reserved bits are clear and exactly one buffer is named
    function automatic logic grp_valid(input logic [GRP_MSB:GRP_LSB] grp);
        logic [3:0] oh;
        oh = grp[GRP_LSB+3:GRP_LSB];
        return (grp[GRP_MSB:GRP_LSB+4] == 2'b00) && (oh != 4'b0000) &&
               ((oh & (oh - 4'd1)) == 4'b0000);
    endfunction

    // Bit position of the single set buffer bit (only meaningful when grp_valid)
    function automatic logic [1:0] grp_index(input logic [GRP_MSB:GRP_LSB] grp);
        logic [1:0] idx;
        idx = 2'd0;
        if (grp[BUF_2A]) idx = 2'd1;
        if (grp[BUF_1B]) idx = 2'd2;
        if (grp[BUF_2B]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/gnn_inst_fifo.sv
// Circular-buffer instruction queue with head/tail pointers and an occupancy count.
// Latency: data pushed at edge E is visible on pop_dat_o after E (one cycle).
// Backpressure: push_rdy_o drops when full (from registered count only); contents are never overwritten.
module gnn_inst_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld_i,
    output logic         push_rdy_o,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    assign push_rdy_o = (count_q != (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_dat_o  = mem_q[head_q];
    assign push       = push_vld_i && push_rdy_o;
    assign pop        = pop_i && !empty_o;

    // Pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + AW'(1);
        if (pop)  head_d = head_q + AW'(1);
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end

    // Pointer/count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= push_dat_i;
    end

endmodule

// File: rtl/gnn_save_scheduler.sv
// Queues save instructions, gates each on its buffer's compute token, drives one save at a time, then releases the buffer.
// Latency: instruction accepted into an idle, empty scheduler at E0 -> CHECK at E1 -> save_ap_start high after E2.
// Backpressure: inst_ready drops while the queue is full; a single save is outstanding until save_ap_done.
module gnn_save_scheduler
    import gnn_save_sched_pkg::*;
#(
    parameter int SAVE_INST_LENGTH = 128,
    parameter int INST_FIFO_DEPTH  = 4,
    parameter int TOKEN_W          = 4,
    parameter int DONE_CNT_W       = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        inst_valid,
    output logic                        inst_ready,
    input  logic [SAVE_INST_LENGTH-1:0] inst_data,
    output logic                        save_ap_start,
    output logic [SAVE_INST_LENGTH-1:0] save_instruction,
    input  logic                        save_ap_done,
    input  logic [NUM_BUF-1:0]          comp_done,
    output logic [NUM_BUF-1:0]          buf_release,
    output logic                        sched_idle,
    output logic                        err_bad_group,
    output logic                        err_token_ovf,
    output logic [DONE_CNT_W-1:0]       done_count
);

    localparam logic [TOKEN_W-1:0] TOK_MAX = '1;

    state_t                          state_q, state_d;
    logic [SAVE_INST_LENGTH-1:0]     inst_q, inst_d;
    logic                            start_q, start_d;
    logic [NUM_BUF-1:0]              rel_q, rel_d;
    logic [DONE_CNT_W-1:0]           done_cnt_q, done_cnt_d;
    logic                            err_bad_q, err_bad_d;
    logic                            err_ovf_q, err_ovf_d;
    logic [NUM_BUF-1:0][TOKEN_W-1:0] tok_q, tok_d;
    logic [NUM_BUF-1:0]              consume;

    logic                            fifo_pop;
    logic                            fifo_empty;
    logic [SAVE_INST_LENGTH-1:0]     fifo_dat;

    logic                            grp_ok;
    logic [1:0]                      grp_idx;
    logic                            wait_dep;
    logic                            rel_dep;

    gnn_inst_fifo #(
        .W     (SAVE_INST_LENGTH),
        .DEPTH (INST_FIFO_DEPTH)
    ) u_fifo (
        .clk        (aclk),
        .rst        (areset),
        .push_vld_i (inst_valid),
        .push_rdy_o (inst_ready),
        .push_dat_i (inst_data),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_dat),
        .empty_o    (fifo_empty)
    );

    // Decode always looks at the held instruction, which is stable from CHECK through RELEASE
    assign grp_ok   = grp_valid(inst_q[GRP_MSB:GRP_LSB]);
    assign grp_idx  = grp_index(inst_q[GRP_MSB:GRP_LSB]);
    assign wait_dep = inst_q[WAIT_BIT];
    assign rel_dep  = inst_q[REL_BIT];

    assign save_ap_start    = start_q;
    assign save_instruction = inst_q;
    assign buf_release      = rel_q;
    assign done_count       = done_cnt_q;
    assign err_bad_group    = err_bad_q;
    assign err_token_ovf    = err_ovf_q;
    assign sched_idle       = (state_q == S_IDLE) && fifo_empty;

    // Sequencer: pulses are computed on the transition into START/RELEASE so they register high for that state's cycle
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        start_d    = 1'b0;
        rel_d      = '0;
        done_cnt_d = done_cnt_q;
        err_bad_d  = err_bad_q;
        consume    = '0;
        fifo_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    inst_d   = fifo_dat;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!grp_ok) begin
                    err_bad_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (!(wait_dep && (tok_q[grp_idx] == '0))) begin
                    // Dependency satisfied (or not required); a missing token simply holds us here
                    if (wait_dep) consume[grp_idx] = 1'b1;
                    start_d = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (save_ap_done) begin
                    done_cnt_d = done_cnt_q + DONE_CNT_W'(1);
                    if (rel_dep) begin
                        rel_d   = NUM_BUF'(1) << grp_idx;
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Token counters: grant and consume on the same edge cancel; a grant into a saturated counter is flagged and dropped
    always_comb begin
        tok_d     = tok_q;
        err_ovf_d = err_ovf_q;
        for (int i = 0; i < NUM_BUF; i++) begin
            if (comp_done[i] && !consume[i]) begin
                if (tok_q[i] == TOK_MAX) err_ovf_d = 1'b1;
                else                     tok_d[i] = tok_q[i] + TOKEN_W'(1);
            end else if (consume[i] && !comp_done[i]) begin
                tok_d[i] = tok_q[i] - TOKEN_W'(1);
            end
        end
    end

    // State registers; reset discards any in-flight save and all tokens
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= S_IDLE;
            inst_q     <= '0;
            start_q    <= 1'b0;
            rel_q      <= '0;
            done_cnt_q <= '0;
            err_bad_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            tok_q      <= '0;
        end else begin
            state_q    <= state_d;
            inst_q     <= inst_d;
            start_q    <= start_d;
            rel_q      <= rel_d;
            done_cnt_q <= done_cnt_d;
            err_bad_q  <= err_bad_d;
            err_ovf_q  <= err_ovf_d;
            tok_q      <= tok_d;
        end
    end

endmodule

// File: tb/tb_gnn_save_scheduler.sv
// Directed bench for gnn_save_scheduler: decode table plus hand sequences for stalls, queue-full, tokens and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_gnn_save_scheduler;

    logic         aclk = 1'b0;
    logic         areset = 1'b0;
    logic         inst_valid = 1'b0;
    logic         inst_ready;
    logic [127:0] inst_data = '0;
    logic         save_ap_start;
    logic [127:0] save_instruction;
    logic         save_ap_done = 1'b0;
    logic [3:0]   comp_done = 4'b0;
    logic [3:0]   buf_release;
    logic         sched_idle;
    logic         err_bad_group;
    logic         err_token_ovf;
    logic [15:0]  done_count;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int rel_cnt = 0;
    int exp_done = 0;
    logic [127:0] start_log [$];

    gnn_save_scheduler dut (
        .aclk             (aclk),
        .areset           (areset),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_data        (inst_data),
        .save_ap_start    (save_ap_start),
        .save_instruction (save_instruction),
        .save_ap_done     (save_ap_done),
        .comp_done        (comp_done),
        .buf_release      (buf_release),
        .sched_idle       (sched_idle),
        .err_bad_group    (err_bad_group),
        .err_token_ovf    (err_token_ovf),
        .done_count       (done_count)
    );

    always #5 aclk = ~aclk;

    // Record every start pulse and release pulse just after the edge that produced it
    always @(posedge aclk) begin
        #1;
        if (save_ap_start) begin
            start_cnt = start_cnt + 1;
            start_log.push_back(save_instruction);
        end
        if (buf_release != 4'b0) rel_cnt = rel_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mk(input logic [5:0] grp, input logic wt, input logic rl, input logic [7:0] tag);
        logic [127:0] d;
        d = '0;
        d[5:0]     = grp;
        d[6]       = wt;
        d[7]       = rl;
        d[127:120] = tag;
        d[63:32]   = {24'hC0DE00, tag};
        return d;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic push(input logic [127:0] d);
        int n = 0;
        while (!inst_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("push_ready", inst_ready, 1);
        if (inst_ready) begin
            inst_valid = 1'b1;
            inst_data  = d;
            @(negedge aclk);
            inst_valid = 1'b0;
        end
    endtask

    task automatic wait_starts(input int target, input int max_cyc, output bit ok);
        int n = 0;
        while (start_cnt < target && n < max_cyc) begin
            @(negedge aclk);
            n++;
        end
        ok = (start_cnt >= target);
    endtask

    // Called at the negedge where a start was seen; done lands while the FSM is in BUSY
    task automatic pulse_done();
        @(negedge aclk);
        save_ap_done = 1'b1;
        @(negedge aclk);
        save_ap_done = 1'b0;
    endtask

    typedef struct {
        logic [127:0] data;
        logic         exp_start;
        logic [3:0]   exp_rel;
        logic         exp_err;
    } vec_t;

    vec_t vecs [9];

    initial begin
        bit ok;
        int s0;
        int r0;
        logic [127:0] q6 [6];

        vecs[0] = '{mk(6'b000001, 1'b0, 1'b1, 8'h10), 1'b1, 4'b0001, 1'b0};
        vecs[1] = '{mk(6'b001000, 1'b0, 1'b1, 8'h11), 1'b1, 4'b1000, 1'b0};
        vecs[2] = '{mk(6'b000011, 1'b0, 1'b1, 8'h12), 1'b0, 4'b0000, 1'b1};
        vecs[3] = '{mk(6'b000100, 1'b0, 1'b1, 8'h13), 1'b1, 4'b0100, 1'b1};
        vecs[4] = '{mk(6'b000000, 1'b0, 1'b1, 8'h14), 1'b0, 4'b0000, 1'b1};
        vecs[5] = '{mk(6'b010001, 1'b0, 1'b1, 8'h15), 1'b0, 4'b0000, 1'b1};
        vecs[6] = '{mk(6'b000010, 1'b0, 1'b0, 8'h16), 1'b1, 4'b0000, 1'b1};
        vecs[7] = '{mk(6'b000010, 1'b0, 1'b1, 8'h17), 1'b1, 4'b0010, 1'b1};
        vecs[8] = '{mk(6'b100000, 1'b0, 1'b1, 8'h18), 1'b0, 4'b0000, 1'b1};

        // Reset values
        #2 areset = 1'b1;
        #1;
        check("rst_start", save_ap_start, 0);
        check("rst_release", buf_release, 0);
        check("rst_instr", save_instruction, 0);
        check("rst_done_count", done_count, 0);
        check("rst_err_bad", err_bad_group, 0);
        check("rst_err_ovf", err_token_ovf, 0);
        check("rst_ready", inst_ready, 1);
        check("rst_idle", sched_idle, 1);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);

        // Single save with release: exact start latency and one-cycle pulses
        push(mk(6'b000001, 1'b0, 1'b1, 8'h01));
        check("t1_start_e1", save_ap_start, 0);
        @(negedge aclk);
        check("t1_start_e1b", save_ap_start, 0);
        @(negedge aclk);
        check("t1_start_e2", save_ap_start, 1);
        check("t1_instr", save_instruction, mk(6'b000001, 1'b0, 1'b1, 8'h01));
        @(negedge aclk);
        check("t1_start_once", save_ap_start, 0);
        repeat (9) @(negedge aclk);
        save_ap_done = 1'b1;
        @(negedge aclk);
        save_ap_done = 1'b0;
        exp_done++;
        check("t1_release", buf_release, 4'b0001);
        check("t1_done_count", done_count, exp_done);
        @(negedge aclk);
        check("t1_release_once", buf_release, 0);
        check("t1_idle", sched_idle, 1);

        // Group decode table
        for (int i = 0; i < 9; i++) begin
            s0 = start_cnt;
            push(vecs[i].data);
            wait_starts(s0 + 1, 6, ok);
            check($sformatf("tab%0d_start", i), ok, vecs[i].exp_start);
            if (ok) begin
                check($sformatf("tab%0d_instr", i), save_instruction, vecs[i].data);
                pulse_done();
                exp_done++;
                check($sformatf("tab%0d_release", i), buf_release, vecs[i].exp_rel);
                @(negedge aclk);
            end
            check($sformatf("tab%0d_err", i), err_bad_group, vecs[i].exp_err);
            check($sformatf("tab%0d_idle", i), sched_idle, 1);
            check($sformatf("tab%0d_done_count", i), done_count, exp_done);
        end

        // Dependency stall until a token arrives for buffer 1_B
        s0 = start_cnt;
        push(mk(6'b000100, 1'b1, 1'b0, 8'h20));
        repeat (50) @(negedge aclk);
        check("t2_stalled", start_cnt, s0);
        check("t2_not_idle", sched_idle, 0);
        comp_done = 4'b0100;
        @(negedge aclk);
        comp_done = 4'b0000;
        wait_starts(s0 + 1, 2, ok);
        check("t2_start_after_token", ok, 1);
        check("t2_token_consumed", dut.tok_q[2], 0);
        pulse_done();
        exp_done++;
        @(negedge aclk);
        check("t2_done_count", done_count, exp_done);

        // Queue full: four queued plus one held by the FSM
        s0 = start_cnt;
        for (int k = 0; k < 6; k++) q6[k] = mk(6'b000010, 1'b0, 1'b0, 8'h30 + 8'(k));
        for (int k = 0; k < 5; k++) push(q6[k]);
        check("t3_full_ready", inst_ready, 0);
        fork
            push(q6[5]);
            begin
                for (int k = 0; k < 6; k++) begin
                    bit okk;
                    wait_starts(s0 + k + 1, 40, okk);
                    check($sformatf("t3_start%0d", k), okk, 1);
                    if (okk) pulse_done();
                end
            end
        join
        exp_done += 6;
        @(negedge aclk);
        for (int k = 0; k < 6; k++)
            check($sformatf("t3_order%0d", k), (start_log.size() > s0 + k) ? start_log[s0 + k] : '0, q6[k]);
        check("t3_done_count", done_count, exp_done);
        check("t3_idle", sched_idle, 1);

        // Token saturation on buffer 1_A
        comp_done = 4'b0001;
        repeat (15) @(negedge aclk);
        check("t5_tok_at_max", dut.tok_q[0], 15);
        check("t5_no_ovf_yet", err_token_ovf, 0);
        @(negedge aclk);
        comp_done = 4'b0000;
        check("t5_tok_held", dut.tok_q[0], 15);
        check("t5_ovf", err_token_ovf, 1);

        // Grant and consume on the same edge for buffer 2_A
        comp_done = 4'b0010;
        @(negedge aclk);
        comp_done = 4'b0000;
        check("t6_tok_one", dut.tok_q[1], 1);
        push(mk(6'b000010, 1'b1, 1'b0, 8'h40));
        @(negedge aclk);
        comp_done = 4'b0010;
        @(negedge aclk);
        comp_done = 4'b0000;
        check("t6_started", save_ap_start, 1);
        check("t6_tok_unchanged", dut.tok_q[1], 1);
        pulse_done();
        exp_done++;
        @(negedge aclk);
        check("t6_done_count", done_count, exp_done);

        // Reset during BUSY with two instructions queued
        s0 = start_cnt;
        push(mk(6'b000001, 1'b0, 1'b1, 8'h50));
        wait_starts(s0 + 1, 4, ok);
        check("t7_start", ok, 1);
        push(mk(6'b000001, 1'b0, 1'b1, 8'h51));
        push(mk(6'b000001, 1'b0, 1'b1, 8'h52));
        check("t7_busy_not_idle", sched_idle, 0);
        areset = 1'b1;
        #1;
        check("t7_rst_start", save_ap_start, 0);
        check("t7_rst_release", buf_release, 0);
        check("t7_rst_instr", save_instruction, 0);
        check("t7_rst_done_count", done_count, 0);
        check("t7_rst_err_bad", err_bad_group, 0);
        check("t7_rst_err_ovf", err_token_ovf, 0);
        check("t7_rst_ready", inst_ready, 1);
        check("t7_rst_idle", sched_idle, 1);
        check("t7_rst_tok", dut.tok_q[0], 0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        s0 = start_cnt;
        r0 = rel_cnt;
        save_ap_done = 1'b1;
        @(negedge aclk);
        save_ap_done = 1'b0;
        repeat (6) @(negedge aclk);
        check("t7_done_ignored", done_count, 0);
        check("t7_no_start", start_cnt, s0);
        check("t7_no_release", rel_cnt, r0);
        check("t7_idle_after", sched_idle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
